// File: rtl/row_sequencer.sv
// row_sequencer: row-progression engine for the tower-stacking game.
// Tracks the row being built, registers the spawn geometry (y, x, direction)
// of the next moving block and a difficulty setting that speeds up with
// progress. At the top of the tower it either saturates and latches done
// (WRAP_MODE=0) or wraps to row 0 and counts laps (WRAP_MODE=1).
//
// Ports:
//   clk            system clock
//   resetn         asynchronous active-low reset
//   inc_row        one-cycle pulse: placement accepted, advance one row
//   restart        synchronous return to the reset state (new game)
//   row            current row index
//   new_y_position spawn y of the current row
//   new_x_position spawn x of the current row
//   new_direction  1 = move right, 0 = move left
//   difficulty     frames per pixel for the current row
//   top_reached    one-cycle pulse when an increment leaves the last row
//   done           tower complete (WRAP_MODE=0 only)
//   lap            completed laps, saturating at 15 (WRAP_MODE=1 only)
module row_sequencer #(
  parameter int NUM_ROWS      = 7,
  parameter int ROW_W         = 4,
  parameter int Y_BASE        = 104,
  parameter int Y_PITCH       = 16,
  parameter int X_END         = 144,
  parameter int DIFF_START    = 4,
  parameter int DIFF_MIN      = 1,
  parameter int ROWS_PER_STEP = 2,
  parameter int WRAP_MODE     = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc_row,
  input  logic             restart,
  output logic [ROW_W-1:0] row,
  output logic [6:0]       new_y_position,
  output logic [7:0]       new_x_position,
  output logic             new_direction,
  output logic [2:0]       difficulty,
  output logic             top_reached,
  output logic             done,
  output logic [3:0]       lap
);

  localparam int SW = (ROWS_PER_STEP < 2) ? 1 : $clog2(ROWS_PER_STEP + 1);
  localparam logic [ROW_W-1:0] LAST     = ROW_W'(NUM_ROWS - 1);
  localparam logic [SW-1:0]    STEP_END = SW'(ROWS_PER_STEP - 1);

  typedef enum logic {PLAY, DONE} state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [SW-1:0]    step_q, step_d;
  logic [2:0]       diff_q, diff_d;
  logic [3:0]       lap_q, lap_d;
  logic             done_q, done_d;
  logic             top_q, top_d;
  logic [6:0]       y_q, y_d;
  logic [7:0]       x_q, x_d;
  logic             dir_q, dir_d;
  logic             adv;
  logic [7:0]       y8;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    step_d  = step_q;
    diff_d  = diff_q;
    lap_d   = lap_q;
    done_d  = done_q;
    top_d   = 1'b0;
    adv     = 1'b0;
    if (restart) begin
      state_d = PLAY;
      row_d   = '0;
      step_d  = '0;
      diff_d  = 3'(DIFF_START);
      lap_d   = '0;
      done_d  = 1'b0;
    end else if (state_q == PLAY && inc_row) begin
      if (row_q == LAST) begin
        top_d = 1'b1;
        if (WRAP_MODE != 0) begin
          row_d = '0;
          lap_d = (lap_q == 4'hF) ? lap_q : lap_q + 4'd1;
          adv   = 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end else begin
        row_d = row_q + 1'b1;
        adv   = 1'b1;
      end
    end

    // Ramp ticks only on increments that actually move the row.
    if (adv) begin
      if (step_q == STEP_END) begin
        step_d = '0;
        if (diff_q > 3'(DIFF_MIN)) diff_d = diff_q - 3'd1;
      end else begin
        step_d = step_q + 1'b1;
      end
    end

    // Geometry follows the next row so it lands in the same cycle as row.
    y8    = 8'(Y_BASE) - 8'(row_d) * 8'(Y_PITCH);
    y_d   = y8[6:0];
    x_d   = row_d[0] ? 8'(X_END) : 8'd0;
    dir_d = ~row_d[0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= PLAY;
      row_q   <= '0;
      step_q  <= '0;
      diff_q  <= 3'(DIFF_START);
      lap_q   <= '0;
      done_q  <= 1'b0;
      top_q   <= 1'b0;
      y_q     <= 7'(Y_BASE);
      x_q     <= 8'd0;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      step_q  <= step_d;
      diff_q  <= diff_d;
      lap_q   <= lap_d;
      done_q  <= done_d;
      top_q   <= top_d;
      y_q     <= y_d;
      x_q     <= x_d;
      dir_q   <= dir_d;
    end
  end

  assign row            = row_q;
  assign new_y_position = y_q;
  assign new_x_position = x_q;
  assign new_direction  = dir_q;
  assign difficulty     = diff_q;
  assign top_reached    = top_q;
  assign done           = done_q;
  assign lap            = lap_q;

endmodule
